// File: rtl/laser_pulse_gen.sv
// Laser pulse train generator: arm window, programmed width/period/count, graceful stop, fault abort.
// Optional external trigger pacing is compiled in when PULSE_GEN_TRIG_EN is defined.
module laser_pulse_gen #(
    parameter int CNT_W     = 32,
    parameter int NUM_W     = 16,
    parameter int ARM_DELAY = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             fault,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] pulse_period,
    input  logic [NUM_W-1:0] pulse_count,
    output logic             laser_pulse,
    output logic             laser_ready,
    output logic             busy,
    output logic             done,
    output logic             fault_abort,
    output logic             cfg_err,
    output logic [NUM_W-1:0] pulse_num
`ifdef PULSE_GEN_TRIG_EN
    ,
    input  logic             ext_trig,
    input  logic             trig_mode
`endif
);

    // state  | meaning
    // IDLE   | waiting for start, outputs quiet
    // ARM    | laser_ready high, pre-pulse delay
    // HIGH   | laser_pulse high for width cycles
    // LOW    | inter-pulse gap, period-width cycles minimum
    // DONE   | one-cycle done strobe, then IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] period_q;
    logic [NUM_W-1:0] count_q;
    logic             stop_pend;

    logic             timer_zero;
    logic             last_pulse;
    logic             cfg_bad;
    logic             start_ok;
    logic             arm_go;
    logic             low_go;

    assign timer_zero = (timer == '0);
    assign last_pulse = (count_q != '0) && (pulse_num == count_q);
    assign cfg_bad    = (pulse_width == '0) || (pulse_period <= pulse_width);
    assign start_ok   = (state == S_IDLE) && start && !fault && !stop;

`ifdef PULSE_GEN_TRIG_EN
    logic trig_meta;
    logic trig_sync;
    logic trig_prev;
    logic trig_mode_q;
    logic trig_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_meta   <= 1'b0;
            trig_sync   <= 1'b0;
            trig_prev   <= 1'b0;
            trig_mode_q <= 1'b0;
        end else begin
            trig_meta <= ext_trig;
            trig_sync <= trig_meta;
            trig_prev <= trig_sync;
            if (start_ok && !cfg_bad) begin
                trig_mode_q <= trig_mode;
            end
        end
    end

    assign trig_edge = trig_sync & ~trig_prev;
    // Edges outside ARM, or in LOW before the minimum gap has elapsed, are simply not looked at.
    assign arm_go    = trig_mode_q ? trig_edge : timer_zero;
    assign low_go    = timer_zero && (!trig_mode_q || trig_edge);
`else
    assign arm_go    = timer_zero;
    assign low_go    = timer_zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            width_q     <= '0;
            period_q    <= '0;
            count_q     <= '0;
            stop_pend   <= 1'b0;
            laser_pulse <= 1'b0;
            laser_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault_abort <= 1'b0;
            cfg_err     <= 1'b0;
            pulse_num   <= '0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && fault) begin
                // fault outranks stop and completion
                state       <= S_IDLE;
                timer       <= '0;
                stop_pend   <= 1'b0;
                laser_pulse <= 1'b0;
                laser_ready <= 1'b0;
                busy        <= 1'b0;
                fault_abort <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            if (cfg_bad) begin
                                cfg_err <= 1'b1;
                            end else begin
                                width_q     <= pulse_width;
                                period_q    <= pulse_period;
                                count_q     <= pulse_count;
                                cfg_err     <= 1'b0;
                                fault_abort <= 1'b0;
                                pulse_num   <= '0;
                                stop_pend   <= 1'b0;
                                timer       <= CNT_W'(ARM_DELAY - 1);
                                state       <= S_ARM;
                                laser_ready <= 1'b1;
                                busy        <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        if (stop) begin
                            state       <= S_DONE;
                            laser_ready <= 1'b0;
                            done        <= 1'b1;
                        end else if (arm_go) begin
                            state       <= S_HIGH;
                            laser_pulse <= 1'b1;
                            pulse_num   <= pulse_num + 1'b1;
                            timer       <= width_q - 1'b1;
                        end else if (!timer_zero) begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_HIGH: begin
                        if (timer_zero) begin
                            laser_pulse <= 1'b0;
                            if (stop || stop_pend || last_pulse) begin
                                state       <= S_DONE;
                                laser_ready <= 1'b0;
                                done        <= 1'b1;
                                stop_pend   <= 1'b0;
                            end else begin
                                state <= S_LOW;
                                timer <= period_q - width_q - 1'b1;
                            end
                        end else begin
                            // a stop mid-pulse waits for the full width; truncation trips the checker
                            if (stop) begin
                                stop_pend <= 1'b1;
                            end
                            timer <= timer - 1'b1;
                        end
                    end
                    S_LOW: begin
                        if (stop) begin
                            state       <= S_DONE;
                            laser_ready <= 1'b0;
                            done        <= 1'b1;
                        end else if (low_go) begin
                            state       <= S_HIGH;
                            laser_pulse <= 1'b1;
                            pulse_num   <= pulse_num + 1'b1;
                            timer       <= width_q - 1'b1;
                        end else if (!timer_zero) begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state       <= S_IDLE;
                        laser_pulse <= 1'b0;
                        laser_ready <= 1'b0;
                        busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_laser_pulse_gen.sv
// Scoreboard bench for laser_pulse_gen: directed sequences push expected edge/strobe events,
// a negedge monitor detects them on the DUT outputs and compares against the queue.
module tb_laser_pulse_gen;

    localparam int CNT_W = 32;
    localparam int NUM_W = 16;

    localparam int K_RISE = 1;
    localparam int K_FALL = 2;
    localparam int K_DONE = 3;
    localparam int K_CFG  = 4;
    localparam int K_FLT  = 5;

    typedef struct {
        int kind;
        int cyc;
        int num;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             fault = 1'b0;
    logic [CNT_W-1:0] pulse_width = '0;
    logic [CNT_W-1:0] pulse_period = '0;
    logic [NUM_W-1:0] pulse_count = '0;
    logic             laser_pulse;
    logic             laser_ready;
    logic             busy;
    logic             done;
    logic             fault_abort;
    logic             cfg_err;
    logic [NUM_W-1:0] pulse_num;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_err = 0;
    ev_t exp_q[$];

    laser_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W), .ARM_DELAY(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .fault        (fault),
        .pulse_width  (pulse_width),
        .pulse_period (pulse_period),
        .pulse_count  (pulse_count),
        .laser_pulse  (laser_pulse),
        .laser_ready  (laser_ready),
        .busy         (busy),
        .done         (done),
        .fault_abort  (fault_abort),
        .cfg_err      (cfg_err),
        .pulse_num    (pulse_num)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int num);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.num  = num;
        exp_q.push_back(e);
    endtask

    // returns 1 ns after the posedge that starts cycle t
    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int t);
        wait_to(t);
        @(negedge clk);
    endtask

    task automatic do_start(input int w, input int p, input int n);
        pulse_width  = CNT_W'(w);
        pulse_period = CNT_W'(p);
        pulse_count  = NUM_W'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    // Monitor: detect events on the outputs and compare with the head of the queue
    logic prev_pulse = 1'b0;
    logic prev_cfg   = 1'b0;
    logic prev_flt   = 1'b0;

    task automatic observe(input int kind);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event @cyc %0d: kind %0d num %0d, queue empty", cyc, kind, pulse_num);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.num != int'(pulse_num)) begin
                n_err++;
                $display("FAIL event: got kind %0d cyc %0d num %0d, expected kind %0d cyc %0d num %0d",
                         kind, cyc, pulse_num, e.kind, e.cyc, e.num);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (laser_pulse && !prev_pulse) observe(K_RISE);
            if (!laser_pulse && prev_pulse) observe(K_FALL);
            if (done) observe(K_DONE);
            if (cfg_err && !prev_cfg) observe(K_CFG);
            if (fault_abort && !prev_flt) observe(K_FLT);
        end
        prev_pulse = laser_pulse;
        prev_cfg   = cfg_err;
        prev_flt   = fault_abort;
    end

    task automatic expect_case1(input int c);
        push(K_RISE, c + 17, 1);
        push(K_FALL, c + 21, 1);
        push(K_RISE, c + 27, 2);
        push(K_FALL, c + 31, 2);
        push(K_RISE, c + 37, 3);
        push(K_FALL, c + 41, 3);
        push(K_DONE, c + 41, 3);
    endtask

    task automatic levels_case1(input int c, input string tag);
        sample(c + 1);
        chk({tag, "_ready_arm"}, int'(laser_ready), 1);
        chk({tag, "_busy_arm"}, int'(busy), 1);
        sample(c + 16);
        chk({tag, "_pulse_arm_end"}, int'(laser_pulse), 0);
        sample(c + 40);
        chk({tag, "_pulse_last"}, int'(laser_pulse), 1);
        chk({tag, "_ready_last"}, int'(laser_ready), 1);
        sample(c + 41);
        chk({tag, "_ready_done"}, int'(laser_ready), 0);
        chk({tag, "_busy_done"}, int'(busy), 1);
        sample(c + 42);
        chk({tag, "_busy_idle"}, int'(busy), 0);
        chk({tag, "_pulse_num"}, int'(pulse_num), 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // reset values
        sample(2);
        chk("rst_pulse", int'(laser_pulse), 0);
        chk("rst_ready", int'(laser_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fault_abort", int'(fault_abort), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_pulse_num", int'(pulse_num), 0);
        wait_to(4);
        rst = 1'b0;

        // 1: basic 3-pulse train
        wait_to(10);
        c = cyc;
        expect_case1(c);
        do_start(4, 10, 3);
        levels_case1(c, "c1");

        // 2: rejected config, then minimum width/period accepted
        wait_to(c + 45);
        c = cyc;
        push(K_CFG, c + 1, 3);
        do_start(10, 10, 1);
        sample(c + 1);
        chk("c2_cfg_err", int'(cfg_err), 1);
        chk("c2_ready", int'(laser_ready), 0);
        chk("c2_busy", int'(busy), 0);
        sample(c + 2);
        chk("c2_busy_after", int'(busy), 0);
        wait_to(c + 3);
        c = cyc;
        push(K_RISE, c + 17, 1);
        push(K_FALL, c + 18, 1);
        push(K_RISE, c + 19, 2);
        push(K_FALL, c + 20, 2);
        push(K_DONE, c + 20, 2);
        do_start(1, 2, 2);
        sample(c + 1);
        chk("c2_cfg_err_clr", int'(cfg_err), 0);
        chk("c2_pulse_num_clr", int'(pulse_num), 0);
        sample(c + 21);
        chk("c2_busy_end", int'(busy), 0);

        // 3: continuous mode, start-while-busy ignored, stop in 2nd cycle of pulse 4
        wait_to(c + 25);
        c = cyc;
        push(K_RISE, c + 17, 1);
        push(K_FALL, c + 22, 1);
        push(K_RISE, c + 37, 2);
        push(K_FALL, c + 42, 2);
        push(K_RISE, c + 57, 3);
        push(K_FALL, c + 62, 3);
        push(K_RISE, c + 77, 4);
        push(K_FALL, c + 82, 4);
        push(K_DONE, c + 82, 4);
        do_start(5, 20, 0);
        wait_to(c + 30);
        do_start(1, 2, 1);
        wait_to(c + 78);
        pulse_stop();
        sample(c + 81);
        chk("c3_pulse_held", int'(laser_pulse), 1);
        sample(c + 83);
        chk("c3_busy_end", int'(busy), 0);

        // 3b: stop during ARM
        wait_to(c + 86);
        c = cyc;
        push(K_DONE, c + 7, 0);
        do_start(5, 20, 0);
        wait_to(c + 6);
        pulse_stop();

        // 3c: stop during LOW
        wait_to(c + 10);
        c = cyc;
        push(K_RISE, c + 17, 1);
        push(K_FALL, c + 21, 1);
        push(K_DONE, c + 24, 1);
        do_start(4, 10, 0);
        wait_to(c + 23);
        pulse_stop();

        // 4: fault in LOW after pulse 2, then start under fault ignored
        wait_to(c + 30);
        c = cyc;
        push(K_RISE, c + 17, 1);
        push(K_FALL, c + 21, 1);
        push(K_RISE, c + 27, 2);
        push(K_FALL, c + 31, 2);
        push(K_FLT,  c + 33, 2);
        do_start(4, 10, 3);
        wait_to(c + 32);
        fault = 1'b1;
        @(posedge clk);
        #1;
        fault = 1'b0;
        sample(c + 33);
        chk("c4_ready", int'(laser_ready), 0);
        chk("c4_busy", int'(busy), 0);
        chk("c4_done", int'(done), 0);
        wait_to(c + 35);
        fault = 1'b1;
        do_start(4, 10, 3);
        sample(c + 37);
        chk("c4_start_ignored", int'(busy), 0);
        chk("c4_fault_abort_sticky", int'(fault_abort), 1);
        fault = 1'b0;

        // 4b: fault in the middle of a pulse cuts it
        wait_to(c + 40);
        c = cyc;
        push(K_RISE, c + 17, 1);
        push(K_FALL, c + 19, 1);
        push(K_FLT,  c + 19, 1);
        do_start(4, 10, 3);
        sample(c + 1);
        chk("c4b_fault_abort_clr", int'(fault_abort), 0);
        wait_to(c + 18);
        fault = 1'b1;
        @(posedge clk);
        #1;
        fault = 1'b0;

        // 5: async reset mid-pulse, then case-1 timing again
        wait_to(c + 25);
        c = cyc;
        push(K_RISE, c + 17, 1);
        do_start(4, 10, 3);
        sample(c + 18);
        #2;
        rst = 1'b1;
        #1;
        chk("c5_rst_pulse", int'(laser_pulse), 0);
        chk("c5_rst_ready", int'(laser_ready), 0);
        chk("c5_rst_busy", int'(busy), 0);
        chk("c5_rst_pulse_num", int'(pulse_num), 0);
        wait_to(c + 21);
        rst = 1'b0;
        wait_to(c + 24);
        c = cyc;
        expect_case1(c);
        do_start(4, 10, 3);
        levels_case1(c, "c5");

        wait_to(c + 50);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
